// File: rtl/iter_alu.sv
// Execute-stage companion ALU: logic, add/sub and signed compare finish in one
// registered cycle; unsigned multiply and divide iterate one bit per clock.
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic             dz_flag,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MULU = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_e;

  function automatic logic [WIDTH-1:0] sc_result(input logic [2:0] o,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    xs = x;
    ys = y;
    case (o)
      OP_AND:  sc_result = x & y;
      OP_OR:   sc_result = x | y;
      OP_ADD:  sc_result = x + y;
      OP_XOR:  sc_result = x ^ y;
      OP_SUB:  sc_result = x - y;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, (xs < ys)};
      default: sc_result = '0;
    endcase
  endfunction

  // Signed overflow: result sign differs from a when operand signs make it possible.
  function automatic logic sc_overflow(input logic [2:0] o,
                                       input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y,
                                       input logic [WIDTH-1:0] r);
    case (o)
      OP_ADD:  sc_overflow = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      OP_SUB:  sc_overflow = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      default: sc_overflow = 1'b0;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;   // multiplicand or divisor
  logic [WIDTH-1:0]   acc_q, acc_d;   // product high half or partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;     // multiplier/product low half or dividend/quotient
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   sc_res;
  logic               sc_ovf;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_lo_nx;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   div_rem_nx;
  logic [WIDTH-1:0]   div_quo_nx;

  assign sc_res = sc_result(op, a, b);
  assign sc_ovf = sc_overflow(op, a, b, sc_res);

  // One shift-add step (LSB first) and one restoring-division step (MSB first).
  assign mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
  assign mul_lo_nx  = {mul_sum[0], lo_q[WIDTH-1:1]};
  assign div_sh     = {acc_q, lo_q[WIDTH-1]};
  assign div_ge     = div_sh >= {1'b0, opa_q};
  assign div_diff   = div_sh[WIDTH-1:0] - opa_q;
  assign div_rem_nx = div_ge ? div_diff : div_sh[WIDTH-1:0];
  assign div_quo_nx = {lo_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MULU) begin
            state_d = RUN_MUL;
            cnt_d   = '0;
            opa_d   = a;
            lo_d    = b;
            acc_d   = '0;
          end else if (op == OP_DIVU) begin
            state_d = RUN_DIV;
            cnt_d   = '0;
            opa_d   = b;
            lo_d    = a;
            acc_d   = '0;
          end else begin
            result_d    = sc_res;
            result_hi_d = '0;
            zero_d      = (sc_res == '0);
            ovf_d       = sc_ovf;
            dz_d        = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      RUN_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        lo_d  = mul_lo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d     = IDLE;
          cnt_d       = '0;
          result_d    = mul_lo_nx;
          result_hi_d = mul_sum[WIDTH:1];
          zero_d      = (mul_lo_nx == '0);
          ovf_d       = (mul_sum[WIDTH:1] != '0);
          dz_d        = 1'b0;
          done_d      = 1'b1;
        end
      end
      RUN_DIV: begin
        // A zero divisor always "subtracts", giving all-ones quotient and remainder = a.
        acc_d = div_rem_nx;
        lo_d  = div_quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d     = IDLE;
          cnt_d       = '0;
          result_d    = div_quo_nx;
          result_hi_d = div_rem_nx;
          zero_d      = (div_quo_nx == '0);
          ovf_d       = 1'b0;
          dz_d        = (opa_q == '0);
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
      done_q      <= done_d;
    end
  end

  // Working registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    acc_q <= acc_d;
    lo_q  <= lo_d;
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero_flag = zero_q;
  assign ovf_flag  = ovf_q;
  assign dz_flag   = dz_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu at WIDTH=32 with hand-computed expectations.
module tb_iter_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero_flag;
  logic         ovf_flag;
  logic         dz_flag;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  iter_alu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .result    (result),
    .result_hi (result_hi),
    .zero_flag (zero_flag),
    .ovf_flag  (ovf_flag),
    .dz_flag   (dz_flag),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge (E0), then drop start.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
  endtask

  // Called just after E0; counts edges until done, bounded.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd32);
  endtask

  int cyc;
  int ndone;

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    op    = 3'b010;
    a     = 32'd7;
    b     = 32'd9;
    tick();
    tick();
    chk("rst_res",  64'(result), 64'd0);
    chk("rst_hi",   64'(result_hi), 64'd0);
    chk("rst_flag", {61'd0, zero_flag, ovf_flag, dz_flag}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk("rel_done", 64'(done), 64'd0);

    // Single-cycle ops
    issue(3'b010, 32'h7FFF_FFFF, 32'd1);
    chk("add_done", 64'(done), 64'd1);
    chk("add_res",  64'(result), 64'h8000_0000);
    chk("add_ovf",  64'(ovf_flag), 64'd1);
    chk("add_zero", 64'(zero_flag), 64'd0);
    chk("add_busy", 64'(busy), 64'd0);
    tick();
    chk("add_pulse", 64'(done), 64'd0);
    chk("add_hold",  64'(result), 64'h8000_0000);

    issue(3'b100, 32'd5, 32'd5);
    chk("sub_res",  64'(result), 64'd0);
    chk("sub_zero", 64'(zero_flag), 64'd1);
    chk("sub_ovf",  64'(ovf_flag), 64'd0);

    issue(3'b100, 32'h8000_0000, 32'd1);
    chk("subov_res", 64'(result), 64'h7FFF_FFFF);
    chk("subov_ovf", 64'(ovf_flag), 64'd1);

    issue(3'b110, 32'hFFFF_FFFF, 32'd1);
    chk("slt_res", 64'(result), 64'd1);
    issue(3'b110, 32'd1, 32'hFFFF_FFFF);
    chk("slt_res0", 64'(result), 64'd0);

    // Back-to-back: start held across three edges
    start = 1'b1; op = 3'b000; a = 32'hF0F0_1234; b = 32'h0FF0_FF00;
    tick();
    chk("and_res", 64'(result), 64'h00F0_1200);
    chk("and_done", 64'(done), 64'd1);
    op = 3'b001;
    tick();
    chk("or_res",  64'(result), 64'hFFF0_FF34);
    chk("or_done", 64'(done), 64'd1);
    op = 3'b011;
    tick();
    start = 1'b0;
    chk("xor_res", 64'(result), 64'hFF00_ED34);
    chk("xor_hi",  64'(result_hi), 64'd0);
    tick();
    chk("b2b_end", 64'(done), 64'd0);

    // MULU
    issue(3'b101, 32'hFFFF_FFFF, 32'd2);
    chk("mul_busy", 64'(busy), 64'd1);
    chk("mul_nodone", 64'(done), 64'd0);
    wait_done("mul", cyc);
    chk("mul_prod", {result_hi, result}, 64'h0000_0001_FFFF_FFFE);
    chk("mul_ovf",  64'(ovf_flag), 64'd1);
    chk("mul_bidle", 64'(busy), 64'd0);
    tick();
    chk("mul_pulse", 64'(done), 64'd0);

    issue(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul2", cyc);
    chk("mul2_prod", {result_hi, result}, 64'hFFFF_FFFE_0000_0001);

    // DIVU
    issue(3'b111, 32'd100, 32'd7);
    wait_done("div", cyc);
    chk("div_q",  64'(result), 64'd14);
    chk("div_r",  64'(result_hi), 64'd2);
    chk("div_dz", 64'(dz_flag), 64'd0);

    issue(3'b111, 32'hFFFF_FFFF, 32'h10);
    wait_done("div2", cyc);
    chk("div2_q", 64'(result), 64'h0FFF_FFFF);
    chk("div2_r", 64'(result_hi), 64'hF);

    issue(3'b111, 32'd123, 32'd0);
    wait_done("dz", cyc);
    chk("dz_q",    64'(result), 64'hFFFF_FFFF);
    chk("dz_r",    64'(result_hi), 64'd123);
    chk("dz_flag", 64'(dz_flag), 64'd1);

    // Start while busy is ignored
    issue(3'b101, 32'd3, 32'd4);
    cyc = 0;
    ndone = 0;
    while (ndone == 0 && cyc < 40) begin
      if (cyc == 9) begin
        start = 1'b1; op = 3'b010; a = 32'd1; b = 32'd1;
      end
      tick();
      start = 1'b0;
      a = 32'hDEAD_BEEF;
      cyc++;
      if (done) ndone++;
    end
    chk("ign_lat", 64'(cyc), 64'd32);
    chk("ign_res", 64'(result), 64'd12);
    chk("ign_hi",  64'(result_hi), 64'd0);
    issue(3'b010, 32'd5, 32'd6);
    chk("ign_add",  64'(result), 64'd11);
    chk("ign_addd", 64'(done), 64'd1);
    tick();
    chk("ign_end", 64'(done), 64'd0);

    // Reset mid-DIVU
    issue(3'b111, 32'd100, 32'd7);
    repeat (14) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_res", {result_hi, result}, 64'd0);
    chk("mrst_flg", {60'd0, zero_flag, ovf_flag, dz_flag, busy}, 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    ndone = 0;
    repeat (40) begin
      tick();
      if (done) ndone++;
    end
    chk("mrst_nodone", 64'(ndone), 64'd0);
    issue(3'b111, 32'd9, 32'd3);
    wait_done("div3", cyc);
    chk("div3_q", 64'(result), 64'd3);
    chk("div3_r", 64'(result_hi), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
